// File: rtl/srng_pkg.sv
// Shared srng definitions: UART timing default, TX FSM state encoding and word byte order.
package srng_pkg;

    localparam int SRNG_UART_DIVISOR   = 217;
    localparam int SRNG_FIFO_DEPTH     = 4;
    localparam bit SRNG_MSB_BYTE_FIRST = 1'b1;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // The byte on its way out always sits in a fixed lane of the word register.
    function automatic logic [7:0] current_byte(input logic [31:0] word);
        return SRNG_MSB_BYTE_FIRST ? word[31:24] : word[7:0];
    endfunction

    function automatic logic [31:0] advance_word(input logic [31:0] word);
        return SRNG_MSB_BYTE_FIRST ? {word[23:0], 8'h00} : {8'h00, word[31:8]};
    endfunction

endpackage

// File: rtl/srng_fifo.sv
// Synchronous word buffer between the srng reader and the UART serializer.
module srng_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // Flags come from the registered count only, so they never depend on this cycle's requests.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = wr_en && !full;
    assign do_pop  = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/srng_uart_tx.sv
// Streams buffered 32-bit random words out of an 8N1 UART, one byte at a time.
module srng_uart_tx
    import srng_pkg::*;
#(
    parameter int DIVISOR    = SRNG_UART_DIVISOR,
    parameter int FIFO_DEPTH = SRNG_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        word_valid,
    input  logic [31:0] word_data,
    output logic        word_ready,
    output logic        txd,
    output logic        busy
);

    localparam int            TW        = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [TW-1:0] LAST_TICK = TW'(DIVISOR - 1);

    tx_state_t     state;
    tx_state_t     state_next;
    logic [TW-1:0] bit_timer;
    logic [TW-1:0] timer_next;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_next;
    logic [1:0]    byte_idx;
    logic [1:0]    byte_idx_next;
    logic [31:0]   shift_reg;
    logic [31:0]   shift_next;
    logic          txd_q;
    logic          txd_next;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [31:0]   fifo_rd_data;
    logic [7:0]    cur_byte;
    logic          bit_tick;

    srng_fifo #(
        .WIDTH(32),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (word_valid),
        .wr_data (word_data),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign word_ready = !fifo_full;
    assign busy       = !fifo_empty || (state != TX_IDLE);
    assign txd        = txd_q;
    assign cur_byte   = current_byte(shift_reg);
    assign bit_tick   = (bit_timer == LAST_TICK);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= TX_IDLE;
            bit_timer <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            shift_reg <= '0;
            txd_q     <= 1'b1;
        end else begin
            state     <= state_next;
            bit_timer <= timer_next;
            bit_idx   <= bit_idx_next;
            byte_idx  <= byte_idx_next;
            shift_reg <= shift_next;
            txd_q     <= txd_next;
        end
    end

    // The line level is registered from the current state, so txd trails the FSM by one clock.
    always_comb begin
        state_next    = state;
        timer_next    = bit_timer;
        bit_idx_next  = bit_idx;
        byte_idx_next = byte_idx;
        shift_next    = shift_reg;
        fifo_pop      = 1'b0;
        txd_next      = 1'b1;

        if (state != TX_IDLE) begin
            timer_next = bit_tick ? '0 : bit_timer + TW'(1);
        end

        case (state)
            TX_IDLE: begin
                timer_next = '0;
                if (!fifo_empty) begin
                    fifo_pop      = 1'b1;
                    shift_next    = fifo_rd_data;
                    byte_idx_next = '0;
                    bit_idx_next  = '0;
                    state_next    = TX_START;
                end
            end
            TX_START: begin
                txd_next = 1'b0;
                if (bit_tick) begin
                    bit_idx_next = '0;
                    state_next   = TX_DATA;
                end
            end
            TX_DATA: begin
                txd_next = cur_byte[bit_idx];
                if (bit_tick) begin
                    if (bit_idx == 3'd7) begin
                        bit_idx_next = '0;
                        shift_next   = advance_word(shift_reg);
                        state_next   = TX_STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end
            end
            TX_STOP: begin
                txd_next = 1'b1;
                // Chain straight into the next start bit whenever more data is waiting.
                if (bit_tick) begin
                    if (byte_idx != 2'd3) begin
                        byte_idx_next = byte_idx + 2'd1;
                        state_next    = TX_START;
                    end else if (!fifo_empty) begin
                        fifo_pop      = 1'b1;
                        shift_next    = fifo_rd_data;
                        byte_idx_next = '0;
                        state_next    = TX_START;
                    end else begin
                        byte_idx_next = '0;
                        state_next    = TX_IDLE;
                    end
                end
            end
            default: begin
                state_next = TX_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_srng_uart_tx.sv
// Randomized bench for srng_uart_tx: a UART decoder and a byte-queue scoreboard act as the reference.
module tb_srng_uart_tx;

    localparam int DIV_A = 4;
    localparam int DIV_B = 217;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid_a;
    logic [31:0] data_a;
    logic        ready_a;
    logic        txd_a;
    logic        busy_a;
    logic        valid_b;
    logic [31:0] data_b;
    logic        ready_b;
    logic        txd_b;
    logic        busy_b;

    int          cyc = 0;
    int          num_compared = 0;
    int          num_mismatched = 0;
    int          reset_epoch = 0;
    logic [7:0]  exp_bytes[$];
    logic        line_s[0:399];
    logic        busy_s[0:399];

    srng_uart_tx #(.DIVISOR(DIV_A), .FIFO_DEPTH(DEPTH)) dut_a (
        .clk(clk), .reset_n(reset_n), .word_valid(valid_a), .word_data(data_a),
        .word_ready(ready_a), .txd(txd_a), .busy(busy_a)
    );

    srng_uart_tx #(.DIVISOR(DIV_B), .FIFO_DEPTH(DEPTH)) dut_b (
        .clk(clk), .reset_n(reset_n), .word_valid(valid_b), .word_data(data_b),
        .word_ready(ready_b), .txd(txd_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_compared++;
        if (observed !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic void record_accept(input logic [31:0] w);
        for (int b = 0; b < 4; b++) exp_bytes.push_back(w[31 - 8*b -: 8]);
    endfunction

    // Ideal line level for the idx-th sample after the accepting edge of the first word.
    function automatic logic exp_line(input int idx, input logic [31:0] w0, input logic [31:0] w1, input int n);
        int t;
        int b;
        int k;
        logic [31:0] word;
        logic [7:0]  by;
        if (idx < 2) return 1'b1;
        t = (idx - 2) / DIV_A;
        if (t >= 40 * n) return 1'b1;
        word = (t / 40 == 0) ? w0 : w1;
        b = (t % 40) / 10;
        k = t % 10;
        by = word[31 - 8*b -: 8];
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return by[k-1];
    endfunction

    // UART receiver on dut_a: mid-bit sampling, bytes compared in order against the scoreboard.
    initial begin : monitor
        int         ep;
        logic [7:0] rx;
        logic       start_ok;
        logic       stop_ok;
        forever begin
            @(negedge clk);
            if (txd_a === 1'b0) begin
                ep = reset_epoch;
                repeat (DIV_A / 2) @(negedge clk);
                start_ok = (txd_a === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV_A) @(negedge clk);
                    rx[i] = txd_a;
                end
                repeat (DIV_A) @(negedge clk);
                stop_ok = (txd_a === 1'b1);
                if (ep == reset_epoch) begin
                    check_output("start_bit", {31'd0, start_ok}, 32'd1);
                    check_output("stop_bit", {31'd0, stop_ok}, 32'd1);
                    if (exp_bytes.size() == 0) check_output("rx_byte_expected", exp_bytes.size(), 32'd1);
                    else check_output("rx_byte", {24'd0, rx}, {24'd0, exp_bytes.pop_front()});
                end
            end
        end
    end

    task automatic apply_stimulus(input logic [31:0] w, output int accept_cycle);
        int waited = 0;
        @(negedge clk);
        while (ready_a !== 1'b1 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (ready_a !== 1'b1) begin
            check_output("ready_timeout", {31'd0, ready_a}, 32'd1);
            accept_cycle = -1;
            return;
        end
        valid_a = 1'b1;
        data_a  = w;
        @(posedge clk);
        @(negedge clk);
        valid_a = 1'b0;
        accept_cycle = cyc;
        record_accept(w);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy_a !== 1'b0 || exp_bytes.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_output("drain_pending_bytes", exp_bytes.size(), 32'd0);
        check_output("drain_busy", {31'd0, busy_a}, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    // Push one or two words on consecutive edges from idle and record the line sample by sample.
    task automatic capture_frames(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                                  input int nwords, input int nsamp);
        int bad = 0;
        int first = -1;
        @(negedge clk);
        valid_a = 1'b1;
        data_a  = w0;
        @(posedge clk);
        @(negedge clk);
        record_accept(w0);
        if (nwords == 2) data_a = w1;
        else valid_a = 1'b0;
        line_s[0] = txd_a;
        busy_s[0] = busy_a;
        for (int k = 1; k < nsamp; k++) begin
            @(negedge clk);
            if (k == 1 && nwords == 2) begin
                valid_a = 1'b0;
                record_accept(w1);
            end
            line_s[k] = txd_a;
            busy_s[k] = busy_a;
        end
        for (int k = 0; k < nsamp; k++) begin
            if (line_s[k] !== exp_line(k, w0, w1, nwords)) begin
                bad++;
                if (first < 0) first = k;
            end
        end
        check_output($sformatf("%s_bad_samples_first_at_%0d", tag, first), bad, 32'd0);
    endtask

    task automatic held_valid_test();
        logic [31:0] w[5];
        int          acc[5];
        int          n0;
        int          j = 0;
        int          guard = 0;
        logic        r;
        logic        ready_after4 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            w[i]   = $urandom;
            acc[i] = -1;
        end
        apply_stimulus($urandom, n0);
        repeat (10) @(negedge clk);
        valid_a = 1'b1;
        data_a  = w[0];
        while (j < 5 && guard < 1000) begin
            r = ready_a;
            @(posedge clk);
            @(negedge clk);
            guard++;
            if (r === 1'b1) begin
                record_accept(w[j]);
                acc[j] = cyc - n0;
                j++;
                if (j == 4) ready_after4 = ready_a;
                if (j < 5) data_a = w[j];
            end
        end
        valid_a = 1'b0;
        check_output("held_accepts_consecutive", acc[3] - acc[0], 32'd3);
        check_output("held_ready_drop_after_4th", {31'd0, ready_after4}, 32'd0);
        check_output("held_5th_after_first_pop", acc[4], 40 * DIV_A + 2);
        wait_idle();
    endtask

    task automatic simul_push_pop_test();
        int n0;
        int n1;
        int guard = 0;
        logic [31:0] w3 = $urandom;
        apply_stimulus($urandom, n0);
        apply_stimulus($urandom, n1);
        apply_stimulus($urandom, n1);
        while (cyc - n0 < 40 * DIV_A && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check_output("count_before_simul", {29'd0, dut_a.u_fifo.count}, 32'd2);
        valid_a = 1'b1;
        data_a  = w3;
        @(posedge clk);
        @(negedge clk);
        valid_a = 1'b0;
        record_accept(w3);
        check_output("count_after_simul", {29'd0, dut_a.u_fifo.count}, 32'd2);
        check_output("ready_after_simul", {31'd0, ready_a}, 32'd1);
        wait_idle();
    endtask

    task automatic random_traffic_test();
        int n;
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 50)) @(negedge clk);
            apply_stimulus($urandom, n);
        end
        wait_idle();
    endtask

    task automatic bit_period_test();
        logic [31:0] wb;
        int          nb;
        int          g = 0;
        int          run = 0;
        wb = ($urandom & 32'h7EFF_FFFF) | 32'h0100_0000;
        @(negedge clk);
        valid_b = 1'b1;
        data_b  = wb;
        @(posedge clk);
        @(negedge clk);
        valid_b = 1'b0;
        nb = cyc;
        while (txd_b !== 1'b0 && g < 20) begin
            @(negedge clk);
            g++;
        end
        check_output("b_start_latency", cyc - nb, 32'd2);
        while (txd_b === 1'b0 && run < 1000) begin
            run++;
            @(negedge clk);
        end
        check_output("b_start_bit_cycles", run, DIV_B);
        repeat (8 * DIV_B - 1) @(negedge clk);
        check_output("b_bit7_low", {31'd0, txd_b}, 32'd0);
        @(negedge clk);
        run = 0;
        while (txd_b === 1'b1 && run < 1000) begin
            run++;
            @(negedge clk);
        end
        check_output("b_stop_bit_cycles", run, DIV_B);
        g = 0;
        while (busy_b !== 1'b0 && g < 45 * DIV_B) begin
            @(negedge clk);
            g++;
        end
        check_output("b_busy_end", {31'd0, busy_b}, 32'd0);
    endtask

    task automatic reset_abort_test();
        int n0;
        int n1;
        int guard = 0;
        int lows = 0;
        int busys = 0;
        apply_stimulus($urandom, n0);
        for (int i = 0; i < 3; i++) apply_stimulus($urandom, n1);
        while (cyc - n0 < 2 + 24 * DIV_A && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check_output("busy_before_reset", {31'd0, busy_a}, 32'd1);
        #2;
        reset_n = 1'b0;
        reset_epoch++;
        exp_bytes.delete();
        #1;
        check_output("reset_async_txd", {31'd0, txd_a}, 32'd1);
        check_output("reset_async_busy", {31'd0, busy_a}, 32'd0);
        check_output("reset_async_ready", {31'd0, ready_a}, 32'd1);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (txd_a !== 1'b1) lows++;
            if (busy_a !== 1'b0) busys++;
        end
        check_output("post_reset_txd_low_cycles", lows, 32'd0);
        check_output("post_reset_busy_cycles", busys, 32'd0);
    endtask

    initial begin : stimulus
        int lows = 0;
        logic [31:0] w0;
        logic [31:0] w1;
        reset_n = 1'b0;
        valid_a = 1'b0;
        data_a  = '0;
        valid_b = 1'b0;
        data_b  = '0;
        #12;
        check_output("reset_txd", {31'd0, txd_a}, 32'd1);
        check_output("reset_busy", {31'd0, busy_a}, 32'd0);
        check_output("reset_ready", {31'd0, ready_a}, 32'd1);
        check_output("reset_count", {29'd0, dut_a.u_fifo.count}, 32'd0);
        check_output("reset_txd_b", {31'd0, txd_b}, 32'd1);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (txd_a !== 1'b1) lows++;
        end
        check_output("no_frame_without_word", lows, 32'd0);

        capture_frames("single_a5c30f81", 32'hA5C3_0F81, 32'h0, 1, 2 + 40 * DIV_A + 8);
        check_output("single_pre_start_high", {31'd0, line_s[1]}, 32'd1);
        check_output("single_start_at_n2", {31'd0, line_s[2]}, 32'd0);
        check_output("single_busy_after_accept", {31'd0, busy_s[0]}, 32'd1);
        check_output("single_busy_in_last_stop", {31'd0, busy_s[40 * DIV_A - 1]}, 32'd1);
        check_output("single_busy_after_frame", {31'd0, busy_s[40 * DIV_A + 2]}, 32'd0);
        wait_idle();

        w0 = $urandom;
        w1 = $urandom;
        capture_frames("back_to_back", w0, w1, 2, 2 + 80 * DIV_A + 8);
        check_output("back_to_back_busy_end", {31'd0, busy_s[80 * DIV_A + 2]}, 32'd0);
        wait_idle();

        held_valid_test();
        simul_push_pop_test();
        random_traffic_test();
        bit_period_test();
        reset_abort_test();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
